// File: rtl/mips_mul_pkg.sv
// Shared definitions for the iterative multiplier and the HI/LO stage that consumes it.
// Signal codes are common to both sides of the HI/LO write port.
package mips_mul_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [5:0] MULTU_out = 6'b111111;
  localparam logic [5:0] MADDU_out = 6'b111110;
  localparam logic [5:0] SIG_NONE  = 6'b000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // op = 1 selects accumulate into HI/LO, op = 0 selects load.
  function automatic logic [5:0] sig_code(input logic op);
    return op ? MADDU_out : MULTU_out;
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Request/result bundle between the execute stage (master) and mul_seq (slave).
interface mul_seq_if;
  import mips_mul_pkg::*;

  // Handshake: a request (start with op/SrcA/SrcB) is taken on a rising edge only
  // while busy = 0; the master holds it until it sees busy = 0. Results are
  // announced by a one-cycle non-zero Signal with MULAns valid in that cycle.
  logic                 start;
  logic                 op;
  logic [WIDTH-1:0]     SrcA;
  logic [WIDTH-1:0]     SrcB;
  logic                 kill;
  logic                 busy;
  logic [2*WIDTH-1:0]   MULAns;
  logic [5:0]           Signal;

  modport master (
    output start, op, SrcA, SrcB, kill,
    input  busy, MULAns, Signal
  );

  modport slave (
    input  start, op, SrcA, SrcB, kill,
    output busy, MULAns, Signal
  );

endinterface

// File: rtl/mul_step.sv
// One shift-add iteration: add the multiplicand when the multiplier LSB is set,
// then shift the 65-bit {carry, acc_hi, mplier} right by one.
module mul_step
  import mips_mul_pkg::*;
(
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] mplier,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mplier_nxt
);

  logic [WIDTH:0] sum;

  always_comb begin
    // 33-bit sum so the carry out lands in the top bit of the new acc_hi.
    sum        = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_nxt    = sum[WIDTH:1];
    mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
  end

endmodule

// File: rtl/mul_seq.sv
// Iterative 32x32 unsigned multiplier feeding HI/LO: one product bit per cycle,
// 33 cycles from accept to the one-cycle Signal pulse.
module mul_seq
  import mips_mul_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mul_seq_if.slave   bus,
  output state_t     state_dbg
);

  state_t              state;
  logic [WIDTH-1:0]    mcand;
  logic [WIDTH-1:0]    mplier;
  logic [WIDTH-1:0]    acc_hi;
  logic [CNT_W-1:0]    count;
  logic                op_r;
  logic                busy_r;
  logic [2*WIDTH-1:0]  ans_r;
  logic [5:0]          sig_r;

  logic [WIDTH-1:0]    acc_nxt;
  logic [WIDTH-1:0]    mplier_nxt;

  mul_step u_step (
    .acc_hi     (acc_hi),
    .mplier     (mplier),
    .mcand      (mcand),
    .acc_nxt    (acc_nxt),
    .mplier_nxt (mplier_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      count  <= '0;
      op_r   <= 1'b0;
      busy_r <= 1'b0;
      ans_r  <= '0;
      sig_r  <= SIG_NONE;
    end else begin
      case (state)
        IDLE: begin
          sig_r <= SIG_NONE;
          // kill wins over a coincident start.
          if (bus.start && !bus.kill) begin
            mcand  <= bus.SrcA;
            mplier <= bus.SrcB;
            op_r   <= bus.op;
            acc_hi <= '0;
            count  <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (bus.kill) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            acc_hi <= acc_nxt;
            mplier <= mplier_nxt;
            count  <= count + 1'b1;
            if (count == CNT_W'(WIDTH - 1)) begin
              // Last iteration: the step outputs already form the full product.
              ans_r <= {acc_nxt, mplier_nxt};
              sig_r <= sig_code(op_r);
              state <= DONE;
            end
          end
        end
        DONE: begin
          sig_r  <= SIG_NONE;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          sig_r  <= SIG_NONE;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.MULAns = ans_r;
  assign bus.Signal = sig_r;
  assign state_dbg  = state;

endmodule
